// File: rtl/dispc_string_encoder.sv
// Packs a 7-bit ASCII character stream, three per word, into DISPC instruction words
// and writes them to instruction memory at consecutive addresses, optionally followed by EXIT.
module dispc_string_encoder #(
   parameter int unsigned ADDR_W      = 10,
   parameter logic [1:0]  DATATYPE    = 2'b00,
   parameter bit          APPEND_EXIT = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              ch_valid,
   input  logic [6:0]        ch_data,
   input  logic              ch_last,
   output logic              ch_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   input  logic              wr_ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] word_count
);

   localparam int unsigned CHAR_W    = 7;
   localparam int unsigned SLOT_W    = 2;
   localparam logic [5:0]  OPC_DISPC = 6'b011010;
   localparam logic [31:0] EXIT_WORD = 32'h0400_0000;

   typedef struct packed {
      logic [5:0]        opcode;
      logic [1:0]        datatype;
      logic [CHAR_W-1:0] char_a;
      logic [CHAR_W-1:0] char_b;
      logic [CHAR_W-1:0] char_c;
      logic [2:0]        pad;
   } dispc_word_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_EMIT,
      S_EXITW,
      S_FIN
   } state_t;

   state_t            state, state_nxt;
   logic [SLOT_W-1:0] slot_cnt;
   logic [CHAR_W-1:0] char_a, char_b, char_c;
   logic [CHAR_W-1:0] a_nxt, b_nxt, c_nxt;
   logic              last_q;
   logic              accept;
   dispc_word_t       word_c;

   // Next state, character slot fill and packed word for the completing character
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      a_nxt     = char_a;
      b_nxt     = char_b;
      c_nxt     = char_c;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_COLLECT;
         end
         S_COLLECT: begin
            accept = ch_valid & ch_ready;
            if (accept) begin
               case (slot_cnt)
                  2'd0:    a_nxt = ch_data;
                  2'd1:    b_nxt = ch_data;
                  default: c_nxt = ch_data;
               endcase
               if (slot_cnt == 2'd2 || ch_last) state_nxt = S_EMIT;
            end
         end
         S_EMIT: begin
            if (wr_ready) begin
               if (!last_q)          state_nxt = S_COLLECT;
               else if (APPEND_EXIT) state_nxt = S_EXITW;
               else                  state_nxt = S_FIN;
            end
         end
         S_EXITW: begin
            if (wr_ready) state_nxt = S_FIN;
         end
         S_FIN: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      word_c = '{opcode: OPC_DISPC, datatype: DATATYPE, char_a: a_nxt,
                 char_b: b_nxt, char_c: c_nxt, pad: 3'b000};
   end

   // State register plus registered outputs decoded from the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         slot_cnt   <= '0;
         char_a     <= '0;
         char_b     <= '0;
         char_c     <= '0;
         last_q     <= 1'b0;
         ch_ready   <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         word_count <= '0;
      end else begin
         state    <= state_nxt;
         ch_ready <= (state_nxt == S_COLLECT);
         wr_en    <= (state_nxt == S_EMIT) || (state_nxt == S_EXITW);
         busy     <= (state_nxt == S_COLLECT) || (state_nxt == S_EMIT) ||
                     (state_nxt == S_EXITW);
         done     <= (state_nxt == S_FIN);
         case (state)
            S_IDLE: begin
               if (start) begin
                  wr_addr    <= base_addr;
                  word_count <= '0;
                  slot_cnt   <= '0;
                  char_a     <= '0;
                  char_b     <= '0;
                  char_c     <= '0;
                  last_q     <= 1'b0;
               end
            end
            S_COLLECT: begin
               if (accept) begin
                  char_a   <= a_nxt;
                  char_b   <= b_nxt;
                  char_c   <= c_nxt;
                  slot_cnt <= slot_cnt + SLOT_W'(1);
                  last_q   <= ch_last;
                  if (state_nxt == S_EMIT) wr_data <= word_c;
               end
            end
            S_EMIT: begin
               if (wr_ready) begin
                  wr_addr    <= wr_addr + ADDR_W'(1);
                  word_count <= word_count + ADDR_W'(1);
                  slot_cnt   <= '0;
                  char_a     <= '0;
                  char_b     <= '0;
                  char_c     <= '0;
                  if (state_nxt == S_EXITW) wr_data <= EXIT_WORD;
               end
            end
            S_EXITW: begin
               if (wr_ready) begin
                  wr_addr    <= wr_addr + ADDR_W'(1);
                  word_count <= word_count + ADDR_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
